calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Sequential controller for the calculator ALU. Synchronizes and edge-detects the execute button, captures the decoded ALU opcode and the switch operand, drives the ALU for a fixed latency, and commits the result into a 16-bit accumulator shown on the LEDs. It sits between the button/switch pins, the combinational button-to-opcode decoder, and the ALU.

## Interface
- `DATA_W`, 16: accumulator, operand and result width.
- `ALU_LAT`, 1: cycles from operand capture to a valid `alu_res`; must be ≥1.
- `DEBOUNCE_CYCLES`, 4: stable-sample count for the execute button; used only with `CALC_DEBOUNCE_EN`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `btnd`  in  1  execute button, raw and asynchronous.
- `alu_op_n`  in  4  opcode from the button decoder; combinational, level-valid.
- `sw`  in  DATA_W  operand B from the switches.
- `alu_res`  in  DATA_W  ALU result.
- `alu_ovf`  in  1  ALU overflow flag, valid together with `alu_res`.
- `alu_a`  out  DATA_W  operand A, equal to the accumulator.
- `alu_b`  out  DATA_W  registered operand B.
- `alu_op`  out  4  registered opcode.
- `busy`  out  1  high while an operation is in flight.
- `led`  out  DATA_W  accumulator value.
- `ovf_led`  out  1  sticky overflow indicator.

## Operation
- **Button path:** `btnd` passes through a 2-flop synchronizer, then a previous-value flop. The execute pulse is high when the synchronized level is 1 and the previous value is 0.
- **FSM states:** IDLE, WAIT, COMMIT.
- **IDLE:** on an execute pulse, capture `alu_op <= alu_op_n` and `alu_b <= sw`, load the wait counter with `ALU_LAT-1`, and go to WAIT. Otherwise hold.
- **WAIT:** decrement the counter each cycle. When the counter is 0, go to COMMIT.
- **COMMIT:** `acc <= alu_res` and `ovf_led <= ovf_led | alu_ovf`, then go to IDLE.
- **Outputs:** `busy` = (state != IDLE). `alu_a` = `led` = `acc`.
- **Presses while busy:** execute pulses in WAIT or COMMIT are dropped, not queued. A button held across completion does not re-trigger, because a new rising edge is required.
- **Opcode handling:** `alu_op_n` is passed through unmodified, including codes the ALU does not use. No arithmetic is done here, so width handling belongs to the ALU.
- **`ovf_led` clear:** only by reset.

## Timing
- **Reset values:** `acc`, `alu_b`, `alu_op`, the counter, `busy` and `ovf_led` are all 0; state is IDLE. The synchronizer and previous-value flops reset to 1, so a button held through reset release does not fire.
- **Reset mid-operation:** aborts immediately with no commit. All outputs take their reset values while `resetn` is low.
- **Input latency:** 2 cycles from the `btnd` transition to the synchronized level. The pulse lasts exactly 1 cycle.
- **Edge E** (pulse high in IDLE): at E+1, `busy`=1 and `alu_op`/`alu_b` are valid. `alu_res` is sampled in COMMIT, which is cycle E+1+`ALU_LAT`. `led` updates and `busy` falls at E+2+`ALU_LAT`.
- **Busy duration:** `ALU_LAT`+1 cycles.
- **Back-to-back:** a pulse arriving in the first IDLE cycle after COMMIT is accepted. Maximum rate is one operation per `ALU_LAT`+2 cycles.
- **Output hold:** `alu_op` and `alu_b` hold their values from capture until the next capture.

## Configuration
- **`CALC_DEBOUNCE_EN` defined:** a debounced level follows the synchronized level only after `DEBOUNCE_CYCLES` consecutive equal samples. The edge detector uses the debounced level. This adds `DEBOUNCE_CYCLES` cycles of input latency. The debounce counter resets to 0 and the debounced level resets to 1.
- **Not defined:** the edge detector uses the synchronized level directly, and `DEBOUNCE_CYCLES` is ignored.

## Test plan
- **Reset:** hold `resetn`=0 with `btnd`=1, then release with `btnd` still 1 → `led`=0, `busy`=0, `ovf_led`=0, `alu_op`=0, and no operation for 50 cycles.
- **Single operation:** `ALU_LAT`=1, `sw`=16'h0005, `alu_op_n`=4'b0100, ALU model returns a+b, one `btnd` press → `busy` high for 2 cycles, `alu_op`=4'b0100, `led`=16'h0005. A second identical press gives `led`=16'h000A.
- **Held button:** `btnd` held high for 100 cycles → exactly one commit.
- **Press while busy:** `ALU_LAT`=4, second press arrives 2 cycles after the first pulse → one commit only. A press arriving after `busy` falls is accepted.
- **Sticky overflow:** `alu_ovf`=1 on the first operation and 0 on the second → `ovf_led` stays 1 until `resetn` is pulsed, then reads 0.
- **Reset during WAIT:** pull `resetn` low while in WAIT → `busy`=0 and `led`=0 immediately, and no commit after release. With `CALC_DEBOUNCE_EN` defined, a `btnd` glitch lasting `DEBOUNCE_CYCLES`-1 cycles produces no operation.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: synchronizes the execute button, drives the ALU for ALU_LAT cycles and commits
// the result into the LED accumulator. Define CALC_DEBOUNCE_EN to debounce the button first.
module calc_sequencer #(
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned ALU_LAT         = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              btnd,
   input  logic [3:0]        alu_op_n,
   input  logic [DATA_W-1:0] sw,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_ovf,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   output logic              busy,
   output logic [DATA_W-1:0] led,
   output logic              ovf_led
);

   localparam int unsigned     CntW    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StCommit
   } state_e;

   logic              sync1;
   logic              sync2;
   logic              btn_lvl;
   logic              btn_prev;
   logic              exec_pulse;
   state_e            state;
   logic [CntW-1:0]   wait_cnt;
   logic [DATA_W-1:0] acc;

   // Reset to 1 so a button held through reset release does not look like a new press.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btnd;
         sync2 <= sync1;
      end
   end

`ifdef CALC_DEBOUNCE_EN
   localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   logic [DbW-1:0] db_cnt;
   logic           db_lvl;

   // db_cnt counts consecutive samples that disagree with the current debounced level.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         db_cnt <= '0;
         db_lvl <= 1'b1;
      end else if (sync2 == db_lvl) begin
         db_cnt <= '0;
      end else if (db_cnt == DbLast) begin
         db_cnt <= '0;
         db_lvl <= sync2;
      end else begin
         db_cnt <= db_cnt + DbW'(1);
      end
   end

   assign btn_lvl = db_lvl;
`else
   assign btn_lvl = sync2;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btn_prev <= 1'b1;
      end else begin
         btn_prev <= btn_lvl;
      end
   end

   assign exec_pulse = btn_lvl & ~btn_prev;

   // Pulses seen outside StIdle are dropped, never queued.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= StIdle;
         wait_cnt <= '0;
         alu_op   <= '0;
         alu_b    <= '0;
         acc      <= '0;
         busy     <= 1'b0;
         ovf_led  <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (exec_pulse) begin
                  alu_op   <= alu_op_n;
                  alu_b    <= sw;
                  wait_cnt <= CntLoad;
                  busy     <= 1'b1;
                  state    <= StWait;
               end
            end
            StWait: begin
               if (wait_cnt == '0) begin
                  state <= StCommit;
               end else begin
                  wait_cnt <= wait_cnt - CntW'(1);
               end
            end
            StCommit: begin
               acc     <= alu_res;
               ovf_led <= ovf_led | alu_ovf;
               busy    <= 1'b0;
               state   <= StIdle;
            end
            default: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

   assign alu_a = acc;
   assign led   = acc;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: two instances (ALU_LAT 1 and 4) share stimulus; a timeline model
// predicts every output each cycle, plus a vector table and directed corner-case sequences.
`timescale 1ns/1ps
module tb_calc_sequencer;
   localparam int unsigned DW   = 16;
   localparam int          MAXC = 16384;
`ifdef CALC_DEBOUNCE_EN
   localparam int          DEB  = 4;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          btnd = 1'b1;
   logic [3:0]    alu_op_n = '0;
   logic [DW-1:0] sw = '0;
   logic          ovf_in = 1'b0;

   logic [DW-1:0] a_o[2];
   logic [DW-1:0] b_o[2];
   logic [DW-1:0] led_o[2];
   logic [DW-1:0] res_i[2];
   logic [3:0]    op_o[2];
   logic          busy_o[2];
   logic          ovfl_o[2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      case (op)
         4'b0100: return a + b;
         4'b0101: return a - b;
         4'b0110: return a & b;
         4'b0111: return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign res_i[0] = alu_fn(op_o[0], a_o[0], b_o[0]);
   assign res_i[1] = alu_fn(op_o[1], a_o[1], b_o[1]);

   calc_sequencer #(.DATA_W(DW), .ALU_LAT(1), .DEBOUNCE_CYCLES(4)) u_dut1 (
      .clk(clk), .resetn(resetn), .btnd(btnd), .alu_op_n(alu_op_n), .sw(sw),
      .alu_res(res_i[0]), .alu_ovf(ovf_in), .alu_a(a_o[0]), .alu_b(b_o[0]), .alu_op(op_o[0]),
      .busy(busy_o[0]), .led(led_o[0]), .ovf_led(ovfl_o[0])
   );

   calc_sequencer #(.DATA_W(DW), .ALU_LAT(4), .DEBOUNCE_CYCLES(4)) u_dut4 (
      .clk(clk), .resetn(resetn), .btnd(btnd), .alu_op_n(alu_op_n), .sw(sw),
      .alu_res(res_i[1]), .alu_ovf(ovf_in), .alu_a(a_o[1]), .alu_b(b_o[1]), .alu_op(op_o[1]),
      .busy(busy_o[1]), .led(led_o[1]), .ovf_led(ovfl_o[1])
   );

   task automatic check(input string name, input int dut, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, dut, $time, got, exp);
      end
   endtask

   // ---------------- timeline reference model ----------------
   bit  bh[MAXC];
   bit  rs[MAXC];
   bit  lv[MAXC];
   int  cyc = 0;
   bit  rs_edge = 1'b0;

   int            lat[2] = '{1, 4};
   bit            have[2];
   int            e_cyc[2];
   logic [3:0]    cap_op[2];
   logic [3:0]    x_op[2];
   logic [DW-1:0] cap_b[2];
   logic [DW-1:0] x_b[2];
   logic [DW-1:0] x_acc[2];
   logic [DW-1:0] pend_res[2];
   bit            x_ovf[2];
   bit            pend_ovf[2];
   int            ops[2] = '{0, 0};
   int            busy_cyc[2] = '{0, 0};
   bit            busy_prev[2] = '{1'b0, 1'b0};

   function automatic bit sync_at(input int n);
      if (n < 0) return 1'b1;
      if (rs[n]) return 1'b1;
      if (n < 2) return 1'b1;
      return bh[n-2];
   endfunction

   function automatic bit lvl_at(input int n);
      if (n < 0) return 1'b1;
      return lv[n];
   endfunction

   always @(posedge clk) rs_edge = resetn;

   always @(negedge clk) begin
      bit pulse;
      bit xbusy;
      if (cyc < MAXC) begin
         rs[cyc] = !rs_edge || !resetn;
         bh[cyc] = resetn ? btnd : 1'b1;
         if (rs[cyc]) begin
            lv[cyc] = 1'b1;
         end else begin
`ifdef CALC_DEBOUNCE_EN
            bit flip;
            flip = 1'b1;
            for (int k = 1; k <= DEB; k++)
               if (sync_at(cyc - k) == lvl_at(cyc - 1)) flip = 1'b0;
            lv[cyc] = flip ? ~lvl_at(cyc - 1) : lvl_at(cyc - 1);
`else
            lv[cyc] = sync_at(cyc);
`endif
         end
         pulse = !rs[cyc] && lv[cyc] && !lvl_at(cyc - 1);
         for (int d = 0; d < 2; d++) begin
            if (rs[cyc]) begin
               have[d]  = 1'b0;
               x_acc[d] = '0;
               x_ovf[d] = 1'b0;
               x_op[d]  = '0;
               x_b[d]   = '0;
            end else if (have[d]) begin
               if (cyc == e_cyc[d] + 1) begin
                  x_op[d] = cap_op[d];
                  x_b[d]  = cap_b[d];
               end
               if (cyc == e_cyc[d] + 1 + lat[d]) begin
                  pend_res[d] = alu_fn(cap_op[d], x_acc[d], cap_b[d]);
                  pend_ovf[d] = ovf_in;
               end
               if (cyc == e_cyc[d] + 2 + lat[d]) begin
                  x_acc[d] = pend_res[d];
                  x_ovf[d] = x_ovf[d] | pend_ovf[d];
                  have[d]  = 1'b0;
               end
            end
            xbusy = have[d] && (cyc > e_cyc[d]);
            check("sb_busy", d, 32'(busy_o[d]), 32'(xbusy));
            check("sb_led", d, 32'(led_o[d]), 32'(x_acc[d]));
            check("sb_alu_a", d, 32'(a_o[d]), 32'(x_acc[d]));
            check("sb_ovf_led", d, 32'(ovfl_o[d]), 32'(x_ovf[d]));
            check("sb_alu_op", d, 32'(op_o[d]), 32'(x_op[d]));
            check("sb_alu_b", d, 32'(b_o[d]), 32'(x_b[d]));
            if (busy_o[d] && !busy_prev[d]) ops[d]++;
            if (busy_o[d]) busy_cyc[d]++;
            busy_prev[d] = busy_o[d];
            if (!rs[cyc] && !have[d] && pulse) begin
               have[d]   = 1'b1;
               e_cyc[d]  = cyc;
               cap_op[d] = alu_op_n;
               cap_b[d]  = sw;
            end
         end
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [3:0]    op;
      logic [DW-1:0] b;
      bit            ovf;
      logic [DW-1:0] exp_led;
      bit            exp_ovf;
   } vec_t;

   vec_t vt[8];
   int   ops0[2];
   int   bc0[2];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      for (int d = 0; d < 2; d++) begin
         ops0[d] = ops[d];
         bc0[d]  = busy_cyc[d];
      end
   endtask

   task automatic check_ops(input string name, input int exp_delta);
      for (int d = 0; d < 2; d++) check(name, d, 32'(ops[d] - ops0[d]), 32'(exp_delta));
   endtask

   initial begin
      vt[0] = '{4'b0100, 16'h0005, 1'b0, 16'h0005, 1'b0};
      vt[1] = '{4'b0100, 16'h0005, 1'b0, 16'h000A, 1'b0};
      vt[2] = '{4'b0101, 16'h0003, 1'b0, 16'h0007, 1'b0};
      vt[3] = '{4'b0110, 16'h0006, 1'b0, 16'h0006, 1'b0};
      vt[4] = '{4'b0111, 16'h00F0, 1'b0, 16'h00F6, 1'b0};
      vt[5] = '{4'b1111, 16'h00FF, 1'b0, 16'h0009, 1'b0};
      vt[6] = '{4'b0100, 16'hFFFF, 1'b1, 16'h0008, 1'b1};
      vt[7] = '{4'b0000, 16'h1230, 1'b0, 16'h1238, 1'b1};

      // Button held through reset and after release: nothing may fire.
      tick(5);
      resetn = 1'b1;
      snap();
      tick(50);
      for (int d = 0; d < 2; d++) begin
         check("rst_led", d, 32'(led_o[d]), 32'h0);
         check("rst_busy", d, 32'(busy_o[d]), 32'h0);
         check("rst_ovf_led", d, 32'(ovfl_o[d]), 32'h0);
         check("rst_alu_op", d, 32'(op_o[d]), 32'h0);
      end
      check_ops("rst_no_op", 0);
      btnd = 1'b0;
      tick(20);

      for (int i = 0; i < 8; i++) begin
         alu_op_n = vt[i].op;
         sw       = vt[i].b;
         ovf_in   = vt[i].ovf;
         snap();
         btnd = 1'b1;
         tick(8);
         btnd = 1'b0;
         tick(20);
         for (int d = 0; d < 2; d++) begin
            check("vec_led", d, 32'(led_o[d]), 32'(vt[i].exp_led));
            check("vec_ovf_led", d, 32'(ovfl_o[d]), 32'(vt[i].exp_ovf));
            check("vec_alu_op", d, 32'(op_o[d]), 32'(vt[i].op));
            check("vec_alu_b", d, 32'(b_o[d]), 32'(vt[i].b));
            check("vec_busy_len", d, 32'(busy_cyc[d] - bc0[d]), 32'(lat[d] + 1));
         end
         check_ops("vec_one_op", 1);
      end
      ovf_in = 1'b0;

      // Held button: a single commit.
      snap();
      btnd = 1'b1;
      tick(100);
      btnd = 1'b0;
      tick(20);
      check_ops("held_one_op", 1);

`ifndef CALC_DEBOUNCE_EN
      // Second pulse two cycles after the first lands while busy and is dropped.
      snap();
      btnd = 1'b1;
      tick(1);
      btnd = 1'b0;
      tick(1);
      btnd = 1'b1;
      tick(1);
      btnd = 1'b0;
      tick(20);
      check_ops("busy_drop", 1);
`endif
      snap();
      btnd = 1'b1;
      tick(8);
      btnd = 1'b0;
      tick(20);
      check_ops("after_busy_ok", 1);

      // Overflow is sticky until reset.
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
      tick(2);
      for (int d = 0; d < 2; d++) begin
         check("ovf_cleared", d, 32'(ovfl_o[d]), 32'h0);
         check("led_cleared", d, 32'(led_o[d]), 32'h0);
      end

      // Reset while the 4-cycle instance is in WAIT.
      alu_op_n = 4'b0100;
      sw       = 16'h0011;
      btnd     = 1'b1;
      tick(8);
      btnd = 1'b0;
      tick(20);
      check("pre_wait_led", 1, 32'(led_o[1]), 32'h0011);
      btnd = 1'b1;
      for (int i = 0; i < 40 && !busy_o[1]; i++) tick(1);
      check("wait_reached", 1, 32'(busy_o[1]), 32'h1);
      tick(1);
      resetn = 1'b0;
      btnd   = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         check("abort_busy", d, 32'(busy_o[d]), 32'h0);
         check("abort_led", d, 32'(led_o[d]), 32'h0);
      end
      tick(2);
      resetn = 1'b1;
      snap();
      tick(20);
      check_ops("abort_no_op", 0);
      check("abort_led_after", 1, 32'(led_o[1]), 32'h0);

`ifdef CALC_DEBOUNCE_EN
      snap();
      btnd = 1'b1;
      tick(DEB - 1);
      btnd = 1'b0;
      tick(20);
      check_ops("glitch_no_op", 0);
`endif

      // Random traffic against the model, with occasional resets.
      for (int i = 0; i < 300; i++) begin
         btnd     = 1'($urandom_range(0, 1));
         sw       = DW'($urandom);
         alu_op_n = 4'($urandom);
         ovf_in   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            resetn = 1'b0;
            tick($urandom_range(1, 3));
            resetn = 1'b1;
         end
         tick($urandom_range(1, 12));
      end
      btnd = 1'b0;
      tick(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
